ex_stage: RTL

//  Execute stage of the RV32I pipeline: consumes the ID/EX pipeline register outputs, computes
//  the ALU result, load/store address, and branch/jump redirect, and feeds the EX/MEM register.

---
 rtl/ex_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage - ALU, load/store address, branch/jump resolution.
// Define FAST_SHIFT_EN for a single-cycle barrel shifter; default is an iterative 1-bit/cycle shifter that stalls.
module ex_stage #(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] ex_op,
    input  logic [4:0]      rd_in,
    input  logic            we_in,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            use_imm,
    output logic [OP_W-1:0] ex_op_out,
    output logic [4:0]      rd_out,
    output logic            we_out,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] store_data,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            stall_req
);
    logic [XLEN-1:0] a, b, res, sh_res, tgt, addr, sdata;
    logic [4:0] shamt;
    logic valid, is_shift, taken, wr, stall, kill, hold;
    assign a = rs1_val;
    assign b = use_imm ? imm : rs2_val;
    assign shamt = b[4:0];
    assign is_shift = ex_op == 5'd3 || ex_op == 5'd7 || ex_op == 5'd8;
`ifdef FAST_SHIFT_EN
    logic [XLEN-1:0] sra_v;
    assign sra_v = $signed(a) >>> shamt;
    assign sh_res = ex_op == 5'd3 ? a << shamt : ex_op == 5'd7 ? a >> shamt : sra_v;
    assign stall = 1'b0;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;
    logic [XLEN-1:0] acc, acc_nx;
    logic [4:0] cnt, cnt_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            acc <= acc_nx;
            cnt <= cnt_nx;
        end
    end
    // Any non-shift op or unexpected state falls back to IDLE
    always_comb begin
        state_nx = IDLE;
        acc_nx = acc;
        cnt_nx = cnt;
        stall = 1'b0;
        sh_res = a;
        if (is_shift) begin
            case (state)
                IDLE: if (shamt != 5'd0) begin
                    stall = 1'b1;
                    state_nx = SHIFT;
                    acc_nx = a;
                    cnt_nx = shamt;
                end
                SHIFT: if (cnt != 5'd0) begin
                    stall = 1'b1;
                    state_nx = SHIFT;
                    acc_nx = ex_op == 5'd3 ? acc << 1 : {ex_op == 5'd8 && acc[XLEN-1], acc[XLEN-1:1]};
                    cnt_nx = cnt - 5'd1;
                end else sh_res = acc;
                default: state_nx = IDLE;
            endcase
        end
    end
`endif
    always_comb begin
        valid = 1'b1;
        res = '0;
        tgt = '0;
        taken = 1'b0;
        addr = '0;
        sdata = '0;
        wr = we_in;
        case (ex_op)
            5'd1: res = a + b;
            5'd2: res = a - b;
            5'd3, 5'd7, 5'd8: res = sh_res;
            5'd4: res = XLEN'($signed(a) < $signed(b));
            5'd5: res = XLEN'(a < b);
            5'd6: res = a ^ b;
            5'd9: res = a | b;
            5'd10: res = a & b;
            5'd11: res = imm;
            5'd12: res = pc + imm;
            5'd13, 5'd14: begin
                res = pc + XLEN'(4);
                taken = 1'b1;
                tgt = ex_op == 5'd13 ? pc + imm : (a + imm) & ~XLEN'(1);
            end
            5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20: begin
                wr = 1'b0;
                tgt = pc + imm;
                taken = ex_op == 5'd15 ? rs1_val == rs2_val :
                        ex_op == 5'd16 ? rs1_val != rs2_val :
                        ex_op == 5'd17 ? $signed(rs1_val) < $signed(rs2_val) :
                        ex_op == 5'd18 ? $signed(rs1_val) >= $signed(rs2_val) :
                        ex_op == 5'd19 ? rs1_val < rs2_val : rs1_val >= rs2_val;
            end
            5'd21, 5'd22, 5'd23, 5'd24, 5'd25: addr = a + imm;
            5'd26, 5'd27, 5'd28: begin
                addr = a + imm;
                sdata = rs2_val;
                wr = 1'b0;
            end
            default: valid = 1'b0;
        endcase
    end
    // A stalled cycle presents a bubble: no write-back and no redirect
    assign kill = rst || !valid;
    assign hold = kill || stall;
    assign ex_op_out = kill ? '0 : ex_op;
    assign rd_out = kill ? '0 : rd_in;
    assign we_out = hold ? 1'b0 : wr;
    assign result = hold ? '0 : res;
    assign mem_addr = kill ? '0 : addr;
    assign store_data = kill ? '0 : sdata;
    assign br_taken = hold ? 1'b0 : taken;
    assign br_target = kill ? '0 : tgt;
    assign stall_req = kill ? 1'b0 : stall;
endmodule
